// File: rtl/nios_sys_sven_seg_pkg.sv
// Shared constants and the hex-to-segment decode used by the seven-segment scan driver.
package nios_sys_sven_seg_pkg;

  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W-1:0] seg_decode(input logic [NIBBLE_W-1:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/nios_sys_sven_seg_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and flags the terminal count for one cycle.
module nios_sys_sven_seg_prescaler #(
  parameter int REFRESH_DIV = 12000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nios_sys_sven_seg_scan_driver.sv
// Right-entry hex digit buffer with multiplexed seven-segment scan output.
// Optional per-digit decimal point when SVEN_SEG_DP_EN is defined.
module nios_sys_sven_seg_scan_driver
  import nios_sys_sven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 12000,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NIBBLE_W-1:0]            digit_in,
  input  logic                           load,
  input  logic                           clear,
  input  logic                           blank,
  output logic [SEG_W-1:0]               seg_out,
  output logic [NUM_DIGITS-1:0]          digit_sel,
  output logic [NIBBLE_W*NUM_DIGITS-1:0] buf_data,
  output logic [3:0]                     digit_count
`ifdef SVEN_SEG_DP_EN
  ,
  input  logic                           dp_in,
  output logic                           dp_out
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BUF_W = NIBBLE_W * NUM_DIGITS;
  localparam logic [SEG_W-1:0]      SEG_MASK = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_MASK = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [3:0]            CNT_MAX  = 4'(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic                load_d;
  logic                load_armed;
  logic                load_pulse;
  logic                tick;
  logic [BUF_W-1:0]    buf_q;
  logic [3:0]          count_q;
  logic [IDX_W-1:0]    scan_idx;
  logic [NIBBLE_W-1:0] cur_nibble;
  logic                show;

  nios_sys_sven_seg_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // A load still high coming out of reset must not count as an edge until it has been seen low.
  assign load_pulse = load & ~load_d & load_armed;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_d     <= 1'b0;
      load_armed <= 1'b0;
      buf_q      <= '0;
      count_q    <= '0;
      scan_idx   <= '0;
    end else begin
      load_d     <= load;
      load_armed <= load_armed | ~load;
      if (clear) begin
        buf_q   <= '0;
        count_q <= '0;
      end else if (load_pulse) begin
        buf_q <= (buf_q << NIBBLE_W) | BUF_W'(digit_in);
        if (count_q != CNT_MAX) begin
          count_q <= count_q + 4'd1;
        end
      end
      if (tick) begin
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    cur_nibble = buf_q[int'(scan_idx)*NIBBLE_W +: NIBBLE_W];
    show       = ~blank & (4'(scan_idx) < count_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_out   <= SEG_MASK;
      digit_sel <= DIG_MASK;
    end else if (show) begin
      seg_out   <= seg_decode(cur_nibble) ^ SEG_MASK;
      digit_sel <= (NUM_DIGITS'(1) << scan_idx) ^ DIG_MASK;
    end else begin
      seg_out   <= SEG_MASK;
      digit_sel <= DIG_MASK;
    end
  end

`ifdef SVEN_SEG_DP_EN
  logic [NUM_DIGITS-1:0] dp_q;

  // Decimal points shift alongside their nibbles and share the segment polarity.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dp_q   <= '0;
      dp_out <= SEG_MASK[0];
    end else begin
      if (clear) begin
        dp_q <= '0;
      end else if (load_pulse) begin
        dp_q <= (dp_q << 1) | NUM_DIGITS'(dp_in);
      end
      dp_out <= show ? (dp_q[scan_idx] ^ SEG_MASK[0]) : SEG_MASK[0];
    end
  end
`endif

  assign buf_data    = buf_q;
  assign digit_count = count_q;

endmodule
